pipe_control_unit: RTL and testbench

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

---
 rtl/pipe_ctrl_pkg.sv | 109 ++++++++++
 rtl/pipe_control_unit_ctrl_decoder.sv | 119 +++++++++++
 rtl/pipe_control_unit.sv | 158 +++++++++++++++
 tb/tb_pipe_control_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcode/func fields,
// ALUOp codes, M/WB control bit layout and next-address selector.
package pipe_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;  // bgez / bltz, picked by Rt
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // Func field values for R-type
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Rt selector for the REGIMM opcode
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // ALUOp encodings
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDI = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_MUL  = 5'd3;
  localparam logic [4:0] ALU_LW   = 5'd4;
  localparam logic [4:0] ALU_SW   = 5'd5;
  localparam logic [4:0] ALU_SB   = 5'd6;
  localparam logic [4:0] ALU_LH   = 5'd7;
  localparam logic [4:0] ALU_LB   = 5'd8;
  localparam logic [4:0] ALU_SH   = 5'd9;
  localparam logic [4:0] ALU_BGEZ = 5'd10;
  localparam logic [4:0] ALU_BEQ  = 5'd11;
  localparam logic [4:0] ALU_BNE  = 5'd12;
  localparam logic [4:0] ALU_BGTZ = 5'd13;
  localparam logic [4:0] ALU_BLEZ = 5'd14;
  localparam logic [4:0] ALU_BLTZ = 5'd15;
  localparam logic [4:0] ALU_J    = 5'd16;
  localparam logic [4:0] ALU_JR   = 5'd17;
  localparam logic [4:0] ALU_JAL  = 5'd18;
  localparam logic [4:0] ALU_AND  = 5'd19;
  localparam logic [4:0] ALU_ANDI = 5'd20;
  localparam logic [4:0] ALU_OR   = 5'd21;
  localparam logic [4:0] ALU_NOR  = 5'd22;
  localparam logic [4:0] ALU_XOR  = 5'd23;
  localparam logic [4:0] ALU_ORI  = 5'd24;
  localparam logic [4:0] ALU_XORI = 5'd25;
  localparam logic [4:0] ALU_SLL  = 5'd26;
  localparam logic [4:0] ALU_SRL  = 5'd27;
  localparam logic [4:0] ALU_SLT  = 5'd28;
  localparam logic [4:0] ALU_SLTI = 5'd29;

  // M control: bit 4 branch, bits 3:2 store size, bits 1:0 load size
  localparam int M_BRANCH_BIT = 4;
  localparam int M_STORE_HI   = 3;
  localparam int M_STORE_LO   = 2;
  localparam int M_LOAD_HI    = 1;
  localparam int M_LOAD_LO    = 0;

  localparam logic [4:0] M_NONE   = 5'b00000;
  localparam logic [4:0] M_LW     = 5'b00001;
  localparam logic [4:0] M_LB     = 5'b00010;
  localparam logic [4:0] M_LH     = 5'b00011;
  localparam logic [4:0] M_SW     = 5'b00100;
  localparam logic [4:0] M_SB     = 5'b01000;
  localparam logic [4:0] M_SH     = 5'b01100;
  localparam logic [4:0] M_BRANCH = 5'b10000;

  // WB control: bit 1 RegWrite, bit 0 MemtoReg
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  // Next-address selector carried to EX
  typedef enum logic [1:0] {
    ADDCTL_SEQ  = 2'd0,
    ADDCTL_JR   = 2'd1,
    ADDCTL_JUMP = 2'd2
  } addctl_e;

  // Register number written by jal (return address)
  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/pipe_control_unit_ctrl_decoder.sv
// Combinational instruction decoder: maps the IF/ID opcode/func/Rt fields
// to ALUOp, EX/M/WB controls and destination register; flags undecodable
// instructions and forces their controls to zero.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int RA_W    = 5
) (
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic [RA_W-1:0]    rt,
  input  logic [RA_W-1:0]    rd,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_dst,
  output logic [RA_W-1:0]    dest,
  output logic [1:0]         add_ctl,
  output logic [4:0]         m,
  output logic [1:0]         wb,
  output logic               illegal
);

  logic [4:0] alu_code;
  logic       is_jal;

  // Main decode; every path starts from all-zero controls
  always_comb begin
    alu_code = ALU_ADD;
    alu_src  = 1'b0;
    reg_dst  = 1'b0;
    add_ctl  = ADDCTL_SEQ;
    m        = M_NONE;
    wb       = WB_NONE;
    illegal  = 1'b0;
    is_jal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        wb      = WB_ALU;
        case (func)
          FN_ADD: alu_code = ALU_ADD;
          FN_SUB: alu_code = ALU_SUB;
          FN_MUL: alu_code = ALU_MUL;
          FN_AND: alu_code = ALU_AND;
          FN_OR:  alu_code = ALU_OR;
          FN_NOR: alu_code = ALU_NOR;
          FN_XOR: alu_code = ALU_XOR;
          FN_SLL: alu_code = ALU_SLL;
          FN_SRL: alu_code = ALU_SRL;
          FN_SLT: alu_code = ALU_SLT;
          FN_JR: begin
            // jr only redirects fetch; it writes no register
            alu_code = ALU_JR;
            reg_dst  = 1'b0;
            wb       = WB_NONE;
            m        = M_BRANCH;
            add_ctl  = ADDCTL_JR;
          end
          default: begin
            reg_dst = 1'b0;
            wb      = WB_NONE;
            illegal = 1'b1;
          end
        endcase
      end
      OP_REGIMM: begin
        if (5'(rt) == RT_BGEZ) begin
          alu_code = ALU_BGEZ;
          m        = M_BRANCH;
        end else if (5'(rt) == RT_BLTZ) begin
          alu_code = ALU_BLTZ;
          m        = M_BRANCH;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J: begin
        alu_code = ALU_J;
        m        = M_BRANCH;
        add_ctl  = ADDCTL_JUMP;
      end
      OP_JAL: begin
        alu_code = ALU_JAL;
        m        = M_BRANCH;
        add_ctl  = ADDCTL_JUMP;
        wb       = WB_ALU;
        is_jal   = 1'b1;
      end
      OP_BEQ:  begin alu_code = ALU_BEQ;  m = M_BRANCH; end
      OP_BNE:  begin alu_code = ALU_BNE;  m = M_BRANCH; end
      OP_BLEZ: begin alu_code = ALU_BLEZ; m = M_BRANCH; end
      OP_BGTZ: begin alu_code = ALU_BGTZ; m = M_BRANCH; end
      OP_ADDI: begin alu_code = ALU_ADDI; alu_src = 1'b1; wb = WB_ALU; end
      OP_SLTI: begin alu_code = ALU_SLTI; alu_src = 1'b1; wb = WB_ALU; end
      OP_ANDI: begin alu_code = ALU_ANDI; alu_src = 1'b1; wb = WB_ALU; end
      OP_ORI:  begin alu_code = ALU_ORI;  alu_src = 1'b1; wb = WB_ALU; end
      OP_XORI: begin alu_code = ALU_XORI; alu_src = 1'b1; wb = WB_ALU; end
      OP_LW:   begin alu_code = ALU_LW; alu_src = 1'b1; m = M_LW; wb = WB_LOAD; end
      OP_LB:   begin alu_code = ALU_LB; alu_src = 1'b1; m = M_LB; wb = WB_LOAD; end
      OP_LH:   begin alu_code = ALU_LH; alu_src = 1'b1; m = M_LH; wb = WB_LOAD; end
      OP_SW:   begin alu_code = ALU_SW; alu_src = 1'b1; m = M_SW; end
      OP_SB:   begin alu_code = ALU_SB; alu_src = 1'b1; m = M_SB; end
      OP_SH:   begin alu_code = ALU_SH; alu_src = 1'b1; m = M_SH; end
      default: illegal = 1'b1;
    endcase
  end

  // Destination select: jal links to r31, R-type writes Rd, others Rt
  always_comb begin
    if (illegal)      dest = '0;
    else if (is_jal)  dest = RA_W'(REG_RA);
    else if (reg_dst) dest = rd;
    else              dest = rt;
  end

  assign alu_op = ALUOP_W'(alu_code);

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control unit: decodes the IF/ID instruction, carries controls
// through ID/EX, EX/MEM and MEM/WB, detects load-use hazards and branch
// flushes, and counts stall and flush cycles with saturation.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Func,
  input  logic [RA_W-1:0]    Rs,
  input  logic [RA_W-1:0]    Rt,
  input  logic [RA_W-1:0]    Rd,
  input  logic               BranchTaken,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic               ALUSrc_EX,
  output logic               RegDst_EX,
  output logic [RA_W-1:0]    Dest_EX,
  output logic [1:0]         AddCtl_EX,
  output logic [4:0]         M_MEM,
  output logic [1:0]         WB_WB,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               Flush,
  output logic               Illegal,
  output logic [CNT_W-1:0]   StallCnt,
  output logic [CNT_W-1:0]   FlushCnt
);

  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_alu_src;
  logic               dec_reg_dst;
  logic [RA_W-1:0]    dec_dest;
  logic [1:0]         dec_add_ctl;
  logic [4:0]         dec_m;
  logic [1:0]         dec_wb;

  logic [ALUOP_W-1:0] id_ex_alu_op_reg;
  logic               id_ex_alu_src_reg;
  logic               id_ex_reg_dst_reg;
  logic [RA_W-1:0]    id_ex_dest_reg;
  logic [1:0]         id_ex_add_ctl_reg;
  logic [4:0]         id_ex_m_reg;
  logic [1:0]         id_ex_wb_reg;
  logic [4:0]         ex_mem_m_reg;
  logic [1:0]         ex_mem_wb_reg;
  logic [1:0]         mem_wb_wb_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   flush_cnt_reg;

  logic load_use;
  logic stall;
  logic bubble;

  ctrl_decoder #(
    .ALUOP_W (ALUOP_W),
    .RA_W    (RA_W)
  ) u_decoder (
    .op      (Op),
    .func    (Func),
    .rt      (Rt),
    .rd      (Rd),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .reg_dst (dec_reg_dst),
    .dest    (dec_dest),
    .add_ctl (dec_add_ctl),
    .m       (dec_m),
    .wb      (dec_wb),
    .illegal (Illegal)
  );

  // A load in EX whose (non-zero) target is read by the IF/ID instruction.
  // The bubble it causes clears ID/EX, so the stall self-terminates after
  // one cycle. A taken branch discards the dependent instruction anyway,
  // so the flush overrides the stall.
  assign load_use = (id_ex_m_reg[M_LOAD_HI:M_LOAD_LO] != 2'b00) &&
                    (id_ex_dest_reg != '0) &&
                    ((id_ex_dest_reg == Rs) || (id_ex_dest_reg == Rt));
  assign stall    = load_use & ~BranchTaken;
  assign bubble   = stall | BranchTaken;

  // Reset clears ID/EX asynchronously, which already releases any stall;
  // Flush is gated so it stays low while reset is held.
  assign PCWrite   = ~stall;
  assign IFIDWrite = ~stall;
  assign Flush     = BranchTaken & Rst_n;

  // ID/EX: take decoded controls, or a zero bubble on stall/flush
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      id_ex_alu_op_reg  <= '0;
      id_ex_alu_src_reg <= 1'b0;
      id_ex_reg_dst_reg <= 1'b0;
      id_ex_dest_reg    <= '0;
      id_ex_add_ctl_reg <= '0;
      id_ex_m_reg       <= '0;
      id_ex_wb_reg      <= '0;
    end else if (bubble) begin
      id_ex_alu_op_reg  <= '0;
      id_ex_alu_src_reg <= 1'b0;
      id_ex_reg_dst_reg <= 1'b0;
      id_ex_dest_reg    <= '0;
      id_ex_add_ctl_reg <= '0;
      id_ex_m_reg       <= '0;
      id_ex_wb_reg      <= '0;
    end else begin
      id_ex_alu_op_reg  <= dec_alu_op;
      id_ex_alu_src_reg <= dec_alu_src;
      id_ex_reg_dst_reg <= dec_reg_dst;
      id_ex_dest_reg    <= dec_dest;
      id_ex_add_ctl_reg <= dec_add_ctl;
      id_ex_m_reg       <= dec_m;
      id_ex_wb_reg      <= dec_wb;
    end
  end

  // EX/MEM and MEM/WB advance unconditionally every cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_mem_m_reg  <= '0;
      ex_mem_wb_reg <= '0;
      mem_wb_wb_reg <= '0;
    end else begin
      ex_mem_m_reg  <= id_ex_m_reg;
      ex_mem_wb_reg <= id_ex_wb_reg;
      mem_wb_wb_reg <= ex_mem_wb_reg;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (BranchTaken && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign ALUOp_EX  = id_ex_alu_op_reg;
  assign ALUSrc_EX = id_ex_alu_src_reg;
  assign RegDst_EX = id_ex_reg_dst_reg;
  assign Dest_EX   = id_ex_dest_reg;
  assign AddCtl_EX = id_ex_add_ctl_reg;
  assign M_MEM     = ex_mem_m_reg;
  assign WB_WB     = mem_wb_wb_reg;
  assign StallCnt  = stall_cnt_reg;
  assign FlushCnt  = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed self-checking bench for pipe_control_unit (CNT_W = 2 so counter
// saturation is reachable quickly).
module tb_pipe_control_unit;

  logic       Clk;
  logic       Rst_n;
  logic [5:0] Op;
  logic [5:0] Func;
  logic [4:0] Rs;
  logic [4:0] Rt;
  logic [4:0] Rd;
  logic       BranchTaken;
  logic [4:0] ALUOp_EX;
  logic       ALUSrc_EX;
  logic       RegDst_EX;
  logic [4:0] Dest_EX;
  logic [1:0] AddCtl_EX;
  logic [4:0] M_MEM;
  logic [1:0] WB_WB;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       Flush;
  logic       Illegal;
  logic [1:0] StallCnt;
  logic [1:0] FlushCnt;

  int checks = 0;
  int errors = 0;

  pipe_control_unit #(
    .ALUOP_W (5),
    .RA_W    (5),
    .CNT_W   (2)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Op          (Op),
    .Func        (Func),
    .Rs          (Rs),
    .Rt          (Rt),
    .Rd          (Rd),
    .BranchTaken (BranchTaken),
    .ALUOp_EX    (ALUOp_EX),
    .ALUSrc_EX   (ALUSrc_EX),
    .RegDst_EX   (RegDst_EX),
    .Dest_EX     (Dest_EX),
    .AddCtl_EX   (AddCtl_EX),
    .M_MEM       (M_MEM),
    .WB_WB       (WB_WB),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .Flush       (Flush),
    .Illegal     (Illegal),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    Op = op; Func = fn; Rs = rs; Rt = rt; Rd = rd;
  endtask

  task automatic do_reset();
    set_instr(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    BranchTaken = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
    #1;
  endtask

  // Decode one instruction and follow its controls down the pipe
  task automatic run_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input int e_alu, input int e_src,
                         input int e_dst, input int e_ac, input int e_dest,
                         input int e_m, input int e_wb, input int e_ill);
    set_instr(op, fn, 5'd7, rt, 5'd6);
    #1;
    check({name, ".illegal"}, 32'(Illegal), e_ill);
    tick();
    check({name, ".aluop"},  32'(ALUOp_EX),  e_alu);
    check({name, ".alusrc"}, 32'(ALUSrc_EX), e_src);
    check({name, ".regdst"}, 32'(RegDst_EX), e_dst);
    check({name, ".addctl"}, 32'(AddCtl_EX), e_ac);
    check({name, ".dest"},   32'(Dest_EX),   e_dest);
    set_instr(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check({name, ".m"}, 32'(M_MEM), e_m);
    tick();
    check({name, ".wb"}, 32'(WB_WB), e_wb);
    $display("vec %s: aluop=%0d dest=%0d m=%b wb=%b", name, e_alu, e_dest, e_m[4:0], e_wb[1:0]);
  endtask

  initial begin
    Rst_n = 1'b0;
    BranchTaken = 1'b0;
    set_instr(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    #3;
    // Reset state
    check("rst.pcwrite",  32'(PCWrite),   1);
    check("rst.ifidwrite",32'(IFIDWrite), 1);
    check("rst.stallcnt", 32'(StallCnt),  0);
    check("rst.flushcnt", 32'(FlushCnt),  0);
    check("rst.m",        32'(M_MEM),     0);
    check("rst.wb",       32'(WB_WB),     0);
    BranchTaken = 1'b1;
    #1;
    check("rst.flush",    32'(Flush),     0);
    BranchTaken = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    $display("reset released");

    // add: latency of EX and WB fields
    set_instr(6'b000000, 6'b100000, 5'd1, 5'd3, 5'd5);
    tick();
    check("add.aluop", 32'(ALUOp_EX), 0);
    check("add.dest",  32'(Dest_EX),  5);
    check("add.regdst",32'(RegDst_EX),1);
    set_instr(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    check("add.wb_early", 32'(WB_WB), 0);
    tick();
    tick();
    check("add.wb", 32'(WB_WB), 2);
    $display("add latency sequence done");

    // Decode table: name op func rt | alu src dst ac dest m wb illegal
    run_vec("add",   6'b000000, 6'b100000, 5'd4,  0, 0, 1, 0,  6, 5'b00000, 2'b10, 0);
    run_vec("sub",   6'b000000, 6'b100010, 5'd4,  2, 0, 1, 0,  6, 5'b00000, 2'b10, 0);
    run_vec("slt",   6'b000000, 6'b101010, 5'd4, 28, 0, 1, 0,  6, 5'b00000, 2'b10, 0);
    run_vec("jr",    6'b000000, 6'b001000, 5'd4, 17, 0, 0, 1,  4, 5'b10000, 2'b00, 0);
    run_vec("lw",    6'b100011, 6'b000000, 5'd4,  4, 1, 0, 0,  4, 5'b00001, 2'b11, 0);
    run_vec("lb",    6'b100000, 6'b000000, 5'd4,  8, 1, 0, 0,  4, 5'b00010, 2'b11, 0);
    run_vec("lh",    6'b100001, 6'b000000, 5'd4,  7, 1, 0, 0,  4, 5'b00011, 2'b11, 0);
    run_vec("sw",    6'b101011, 6'b000000, 5'd4,  5, 1, 0, 0,  4, 5'b00100, 2'b00, 0);
    run_vec("sb",    6'b101000, 6'b000000, 5'd4,  6, 1, 0, 0,  4, 5'b01000, 2'b00, 0);
    run_vec("sh",    6'b101001, 6'b000000, 5'd4,  9, 1, 0, 0,  4, 5'b01100, 2'b00, 0);
    run_vec("addi",  6'b001000, 6'b000000, 5'd4,  1, 1, 0, 0,  4, 5'b00000, 2'b10, 0);
    run_vec("ori",   6'b001101, 6'b000000, 5'd4, 24, 1, 0, 0,  4, 5'b00000, 2'b10, 0);
    run_vec("beq",   6'b000100, 6'b000000, 5'd4, 11, 0, 0, 0,  4, 5'b10000, 2'b00, 0);
    run_vec("bgez",  6'b000001, 6'b000000, 5'd1, 10, 0, 0, 0,  1, 5'b10000, 2'b00, 0);
    run_vec("bltz",  6'b000001, 6'b000000, 5'd0, 15, 0, 0, 0,  0, 5'b10000, 2'b00, 0);
    run_vec("j",     6'b000010, 6'b000000, 5'd4, 16, 0, 0, 2,  4, 5'b10000, 2'b00, 0);
    run_vec("jal",   6'b000011, 6'b000000, 5'd4, 18, 0, 0, 2, 31, 5'b10000, 2'b10, 0);
    run_vec("op3f",  6'b111111, 6'b000000, 5'd4,  0, 0, 0, 0,  0, 5'b00000, 2'b00, 1);
    run_vec("rimm2", 6'b000001, 6'b000000, 5'd2,  0, 0, 0, 0,  0, 5'b00000, 2'b00, 1);
    run_vec("badfn", 6'b000000, 6'b111111, 5'd4,  0, 0, 0, 0,  0, 5'b00000, 2'b00, 1);

    // Load-use: lw $2 then add using $2
    do_reset();
    set_instr(6'b100011, 6'd0, 5'd0, 5'd2, 5'd0);
    tick();
    set_instr(6'b000000, 6'b100000, 5'd2, 5'd3, 5'd4);
    #1;
    check("lu.pcwrite",   32'(PCWrite),   0);
    check("lu.ifidwrite", 32'(IFIDWrite), 0);
    check("lu.flush",     32'(Flush),     0);
    tick();
    check("lu.bubble_dest", 32'(Dest_EX),  0);
    check("lu.bubble_rd",   32'(RegDst_EX),0);
    check("lu.stallcnt",    32'(StallCnt), 1);
    check("lu.pc_release",  32'(PCWrite),  1);
    check("lu.lw_in_mem",   32'(M_MEM),    5'b00001);
    tick();
    check("lu.add_dest",    32'(Dest_EX),  4);
    check("lu.stallcnt2",   32'(StallCnt), 1);
    $display("load-use stall sequence done");

    // lw to $0 never stalls
    do_reset();
    set_instr(6'b100011, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    set_instr(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd4);
    #1;
    check("r0.pcwrite", 32'(PCWrite), 1);
    tick();
    check("r0.dest",     32'(Dest_EX),  4);
    check("r0.stallcnt", 32'(StallCnt), 0);
    $display("lw \\$0 sequence done");

    // Branch coincident with load-use: flush wins
    do_reset();
    set_instr(6'b100011, 6'd0, 5'd0, 5'd2, 5'd0);
    tick();
    set_instr(6'b000000, 6'b100000, 5'd2, 5'd3, 5'd4);
    BranchTaken = 1'b1;
    #1;
    check("bt.flush",     32'(Flush),     1);
    check("bt.pcwrite",   32'(PCWrite),   1);
    check("bt.ifidwrite", 32'(IFIDWrite), 1);
    tick();
    BranchTaken = 1'b0;
    check("bt.flushcnt", 32'(FlushCnt), 1);
    check("bt.stallcnt", 32'(StallCnt), 0);
    check("bt.bubble",   32'(Dest_EX),  0);
    $display("branch+hazard sequence done");

    // Stall counter saturation over five stall events
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_instr(6'b100011, 6'd0, 5'd0, 5'd2, 5'd0);
      tick();
      set_instr(6'b000000, 6'b100000, 5'd3, 5'd2, 5'd4);
      #1;
      check("sat.pcwrite", 32'(PCWrite), 0);
      tick();
      tick();
      check("sat.stallcnt", 32'(StallCnt), (i + 1 > 3) ? 3 : i + 1);
      $display("stall event %0d done", i + 1);
    end

    // Flush counter saturation
    do_reset();
    BranchTaken = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    BranchTaken = 1'b0;
    check("fsat.flushcnt", 32'(FlushCnt), 3);
    $display("flush saturation done");

    // Reset asserted mid-stall
    do_reset();
    set_instr(6'b100011, 6'd0, 5'd0, 5'd2, 5'd0);
    tick();
    set_instr(6'b000000, 6'b100000, 5'd2, 5'd3, 5'd4);
    #1;
    check("mr.pre_pcwrite", 32'(PCWrite), 0);
    #1;
    Rst_n = 1'b0;
    BranchTaken = 1'b1;
    #1;
    check("mr.pcwrite",   32'(PCWrite),   1);
    check("mr.ifidwrite", 32'(IFIDWrite), 1);
    check("mr.flush",     32'(Flush),     0);
    check("mr.dest",      32'(Dest_EX),   0);
    check("mr.aluop",     32'(ALUOp_EX),  0);
    BranchTaken = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    check("mr.stallcnt", 32'(StallCnt), 0);
    check("mr.add_dest", 32'(Dest_EX),  4);
    $display("mid-stall reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
